// File: rtl/exe_stage_muldiv_if.sv
// Bus between the ID->EXE pipeline register, the execute stage and the EXE->MEM side.
// master: the upstream/downstream environment; slave: exe_stage_muldiv.
interface exe_stage_muldiv_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CMD_W  = 4
);
  // upstream command, operands and control
  logic              i_valid;
  logic [CMD_W-1:0]  i_Execute_cmd_in;
  logic [DATA_W-1:0] i_value1_in;
  logic [DATA_W-1:0] i_value2_in;
  logic [DATA_W-1:0] i_ST_value;
  logic [ADDR_W-1:0] i_dest_in;
  logic              i_writeback_en_in;
  logic              i_MEM_Rd_en;
  logic              i_MEM_Wr_en;
  logic              i_flush;
  // stall back to the ID->EXE register
  logic              o_stall;
  // registered EXE->MEM results
  logic              o_valid;
  logic [DATA_W-1:0] o_ALU_result;
  logic [DATA_W-1:0] o_ST_value;
  logic [ADDR_W-1:0] o_dest_out;
  logic              o_writeback_en_out;
  logic              o_MEM_Rd_en;
  logic              o_MEM_Wr_en;

  modport master (
    output i_valid, i_Execute_cmd_in, i_value1_in, i_value2_in, i_ST_value,
           i_dest_in, i_writeback_en_in, i_MEM_Rd_en, i_MEM_Wr_en, i_flush,
    input  o_stall, o_valid, o_ALU_result, o_ST_value, o_dest_out,
           o_writeback_en_out, o_MEM_Rd_en, o_MEM_Wr_en
  );

  modport slave (
    input  i_valid, i_Execute_cmd_in, i_value1_in, i_value2_in, i_ST_value,
           i_dest_in, i_writeback_en_in, i_MEM_Rd_en, i_MEM_Wr_en, i_flush,
    output o_stall, o_valid, o_ALU_result, o_ST_value, o_dest_out,
           o_writeback_en_out, o_MEM_Rd_en, o_MEM_Wr_en
  );
endinterface

// File: rtl/exe_stage_muldiv.sv
// Execute stage: single-cycle ALU plus an iterative one-bit-per-clock MUL/DIVU/REMU unit.
// Optional feature macro: EXE_DIV_EN. When defined, DIVU/REMU run on the iterative
// restoring divider; when undefined the divider is not built and cmd 12/13 complete in
// one cycle with result 0.
module exe_stage_muldiv #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CMD_W  = 4
) (
  input logic               i_sys_clk,
  input logic               i_sys_rst,
  exe_stage_muldiv_if.slave bus
);

  localparam int SH_W  = $clog2(DATA_W);
  localparam int CNT_W = $clog2(DATA_W);

  localparam logic [CMD_W-1:0] CMD_ADD  = CMD_W'(1);
  localparam logic [CMD_W-1:0] CMD_SUB  = CMD_W'(2);
  localparam logic [CMD_W-1:0] CMD_AND  = CMD_W'(3);
  localparam logic [CMD_W-1:0] CMD_OR   = CMD_W'(4);
  localparam logic [CMD_W-1:0] CMD_NOR  = CMD_W'(5);
  localparam logic [CMD_W-1:0] CMD_XOR  = CMD_W'(6);
  localparam logic [CMD_W-1:0] CMD_SLL  = CMD_W'(7);
  localparam logic [CMD_W-1:0] CMD_SRL  = CMD_W'(8);
  localparam logic [CMD_W-1:0] CMD_SRA  = CMD_W'(9);
  localparam logic [CMD_W-1:0] CMD_SLT  = CMD_W'(10);
  localparam logic [CMD_W-1:0] CMD_MUL  = CMD_W'(11);
`ifdef EXE_DIV_EN
  localparam logic [CMD_W-1:0] CMD_DIVU = CMD_W'(12);
  localparam logic [CMD_W-1:0] CMD_REMU = CMD_W'(13);
`endif

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [CMD_W-1:0]  op_cmd_reg;
  // acc: MUL accumulator / DIV partial remainder
  // opa: MUL multiplicand (shifts left) / DIV dividend-then-quotient (shifts left)
  // opb: MUL multiplier (shifts right) / DIV divisor
  logic [DATA_W-1:0] acc_reg, opa_reg, opb_reg;
  logic [DATA_W-1:0] acc_next, opa_next, opb_next;

  // control captured at accept, released with the multi-cycle result
  logic [DATA_W-1:0] hold_st_value_reg;
  logic [ADDR_W-1:0] hold_dest_reg;
  logic              hold_wb_reg, hold_rd_reg, hold_wr_reg;

  // registered EXE->MEM outputs
  logic              valid_reg;
  logic [DATA_W-1:0] result_reg;
  logic [DATA_W-1:0] st_value_reg;
  logic [ADDR_W-1:0] dest_reg;
  logic              wb_reg, rd_reg, wr_reg;

  logic              is_multi;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] done_result;
  logic [SH_W-1:0]   sh_amt;

  assign sh_amt = bus.i_value2_in[SH_W-1:0];

`ifdef EXE_DIV_EN
  assign is_multi = (bus.i_Execute_cmd_in == CMD_MUL) ||
                    (bus.i_Execute_cmd_in == CMD_DIVU) ||
                    (bus.i_Execute_cmd_in == CMD_REMU);
`else
  assign is_multi = (bus.i_Execute_cmd_in == CMD_MUL);
`endif

  // Single-cycle ALU; NOP, unused codes and multi-cycle codes produce 0
  always_comb begin
    alu_result = '0;
    case (bus.i_Execute_cmd_in)
      CMD_ADD: alu_result = bus.i_value1_in + bus.i_value2_in;
      CMD_SUB: alu_result = bus.i_value1_in - bus.i_value2_in;
      CMD_AND: alu_result = bus.i_value1_in & bus.i_value2_in;
      CMD_OR:  alu_result = bus.i_value1_in | bus.i_value2_in;
      CMD_NOR: alu_result = ~(bus.i_value1_in | bus.i_value2_in);
      CMD_XOR: alu_result = bus.i_value1_in ^ bus.i_value2_in;
      CMD_SLL: alu_result = bus.i_value1_in << sh_amt;
      CMD_SRL: alu_result = bus.i_value1_in >> sh_amt;
      CMD_SRA: alu_result = $unsigned($signed(bus.i_value1_in) >>> sh_amt);
      CMD_SLT: alu_result = {{(DATA_W-1){1'b0}},
                             ($signed(bus.i_value1_in) < $signed(bus.i_value2_in))};
      default: alu_result = '0;
    endcase
  end

`ifdef EXE_DIV_EN
  logic [DATA_W:0] rem_shift;
  logic [DATA_W:0] rem_diff;
`endif

  // One iteration of the multi-cycle unit: shift-add multiply or restoring divide
  always_comb begin
    acc_next = acc_reg;
    opa_next = opa_reg;
    opb_next = opb_reg;
`ifdef EXE_DIV_EN
    rem_shift = {acc_reg, opa_reg[DATA_W-1]};
    rem_diff  = rem_shift - {1'b0, opb_reg};
`endif
    if (op_cmd_reg == CMD_MUL) begin
      acc_next = opb_reg[0] ? (acc_reg + opa_reg) : acc_reg;
      opa_next = opa_reg << 1;
      opb_next = opb_reg >> 1;
    end
`ifdef EXE_DIV_EN
    else if (!rem_diff[DATA_W]) begin
      // trial subtraction fits: keep difference, shift in quotient bit 1
      acc_next = rem_diff[DATA_W-1:0];
      opa_next = {opa_reg[DATA_W-2:0], 1'b1};
    end else begin
      // restore: keep shifted remainder, shift in quotient bit 0
      acc_next = rem_shift[DATA_W-1:0];
      opa_next = {opa_reg[DATA_W-2:0], 1'b0};
    end
`endif
  end

  // Final value of the op, taken from the last iteration's next-state values
`ifdef EXE_DIV_EN
  assign done_result = (op_cmd_reg == CMD_DIVU) ? opa_next : acc_next;
`else
  assign done_result = acc_next;
`endif

  // Hold upstream while a multi-cycle op is being accepted or still iterating; a flush releases it
  assign bus.o_stall = !bus.i_flush &&
                       (((state_reg == IDLE) && bus.i_valid && is_multi) ||
                        ((state_reg == BUSY) && (cnt_reg != '0)));

  // FSM, iteration datapath and registered EXE->MEM outputs
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state_reg         <= IDLE;
      cnt_reg           <= '0;
      op_cmd_reg        <= '0;
      acc_reg           <= '0;
      opa_reg           <= '0;
      opb_reg           <= '0;
      hold_st_value_reg <= '0;
      hold_dest_reg     <= '0;
      hold_wb_reg       <= 1'b0;
      hold_rd_reg       <= 1'b0;
      hold_wr_reg       <= 1'b0;
      valid_reg         <= 1'b0;
      result_reg        <= '0;
      st_value_reg      <= '0;
      dest_reg          <= '0;
      wb_reg            <= 1'b0;
      rd_reg            <= 1'b0;
      wr_reg            <= 1'b0;
    end else if (bus.i_flush) begin
      // abort any in-flight op and drop the current input; data outputs hold
      state_reg <= IDLE;
      cnt_reg   <= '0;
      valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.i_valid && is_multi) begin
            state_reg         <= BUSY;
            cnt_reg           <= CNT_W'(DATA_W-1);
            op_cmd_reg        <= bus.i_Execute_cmd_in;
            acc_reg           <= '0;
            opa_reg           <= bus.i_value1_in;
            opb_reg           <= bus.i_value2_in;
            hold_st_value_reg <= bus.i_ST_value;
            hold_dest_reg     <= bus.i_dest_in;
            hold_wb_reg       <= bus.i_writeback_en_in;
            hold_rd_reg       <= bus.i_MEM_Rd_en;
            hold_wr_reg       <= bus.i_MEM_Wr_en;
            valid_reg         <= 1'b0;
          end else if (bus.i_valid) begin
            valid_reg    <= 1'b1;
            result_reg   <= alu_result;
            st_value_reg <= bus.i_ST_value;
            dest_reg     <= bus.i_dest_in;
            wb_reg       <= bus.i_writeback_en_in;
            rd_reg       <= bus.i_MEM_Rd_en;
            wr_reg       <= bus.i_MEM_Wr_en;
          end else begin
            valid_reg <= 1'b0;
          end
        end
        BUSY: begin
          acc_reg <= acc_next;
          opa_reg <= opa_next;
          opb_reg <= opb_next;
          cnt_reg <= cnt_reg - 1'b1;
          if (cnt_reg == '0) begin
            state_reg    <= IDLE;
            valid_reg    <= 1'b1;
            result_reg   <= done_result;
            st_value_reg <= hold_st_value_reg;
            dest_reg     <= hold_dest_reg;
            wb_reg       <= hold_wb_reg;
            rd_reg       <= hold_rd_reg;
            wr_reg       <= hold_wr_reg;
          end else begin
            valid_reg <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.o_valid            = valid_reg;
  assign bus.o_ALU_result       = result_reg;
  assign bus.o_ST_value         = st_value_reg;
  assign bus.o_dest_out         = dest_reg;
  assign bus.o_writeback_en_out = wb_reg;
  assign bus.o_MEM_Rd_en        = rd_reg;
  assign bus.o_MEM_Wr_en        = wr_reg;

endmodule
